key_conditioner: RTL and testbench

Multi-channel push-button conditioner sitting directly upstream of the LED display/counter logic. It turns raw, bouncing, asynchronous key inputs into clean, clock-domain-safe signals for downstream counters and state machines:
- a debounced level per key;
- a one-cycle press pulse and a one-cycle release pulse per key;
- auto-repeat pulses while a key is held.

The display controller's reset, restart and count keys are all meant to go through this block.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_if.sv | 23 ++
 rtl/key_channel.sv | 144 ++++++++++++++
 rtl/key_conditioner.sv | 39 +++
 tb/tb_key_conditioner.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and width helpers for the key conditioner.
// key_channel and key_conditioner import this package.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    localparam int STATE_W = 2;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_DB_W   = cnt_width(2_000_000);
    localparam int DEF_HOLD_W = cnt_width(max_int(100_000_000, 10_000_000));

endpackage

// File: rtl/key_if.sv
// Key bundle between the raw pins (master side) and the conditioner (slave side).
interface key_if #(
    parameter int N_KEYS = 3
);
    // No valid/ready here: key_raw is sampled every cycle, and press/release/repeat
    // are single-cycle qualifiers that are valid exactly in the cycle they are high.
    logic [N_KEYS-1:0]   key_raw;
    logic [N_KEYS-1:0]   key_level;
    logic [N_KEYS-1:0]   key_press;
    logic [N_KEYS-1:0]   key_release;
    logic [N_KEYS-1:0]   key_repeat;
    logic [2*N_KEYS-1:0] dbg_state;

    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_repeat, dbg_state
    );

    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_repeat, dbg_state
    );
endinterface

// File: rtl/key_channel.sv
// One key channel: 2-FF synchronizer, debounce window, press/release pulses
// and the hold/auto-repeat FSM.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_raw,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_repeat,
    output key_state_t dbg_state
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(max_int(LONG_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic              RAW_IDLE  = ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic              s1_q, s1_d, s2_q, s2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    key_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              p, accept, press_evt, release_evt;

    assign p           = ACTIVE_HIGH ? s2_q : ~s2_q;
    assign press_evt   = accept & p;
    assign release_evt = accept & ~p;

    // Any sample agreeing with the current level restarts the window.
    always_comb begin
        s1_d     = key_raw;
        s2_d     = s1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        accept   = 1'b0;
        if (p != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = p;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (press_evt) state_d = HELD;
            end
            HELD: begin
                if (release_evt) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == LONG_LAST) begin
                    state_d = REPEAT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            REPEAT: begin
                if (release_evt) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == REP_LAST) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // A release accepted on a threshold cycle suppresses that repeat.
    always_comb begin
        press_d   = press_evt;
        release_d = release_evt;
        repeat_d  = 1'b0;
        case (state_q)
            HELD:    repeat_d = (hold_q == LONG_LAST) && !release_evt;
            REPEAT:  repeat_d = (hold_q == REP_LAST) && !release_evt;
            default: repeat_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= RAW_IDLE;
            s2_q      <= RAW_IDLE;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = repeat_q;
    assign dbg_state   = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: N_KEYS independent key_channel
// instances whose outputs are concatenated onto the key bundle.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input logic  clk,
    input logic  rst_n,
    key_if.slave kif
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_state_t ch_state;

        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_HIGH     (ACTIVE_HIGH)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw     (kif.key_raw[i]),
            .key_level   (kif.key_level[i]),
            .key_press   (kif.key_press[i]),
            .key_release (kif.key_release[i]),
            .key_repeat  (kif.key_repeat[i]),
            .dbg_state   (ch_state)
        );

        assign kif.dbg_state[STATE_W*i +: STATE_W] = ch_state;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: active-high instance checked against a behavioural
// model every cycle, plus directed scenarios and an active-low instance.
module tb_key_conditioner;
  import key_pkg::*;

  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  key_if #(.N_KEYS(N)) kif_a ();
  key_if #(.N_KEYS(N)) kif_b ();

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1'b1)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .kif(kif_a));

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .ACTIVE_HIGH(1'b0)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .kif(kif_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4*N-1:0] obs_a, obs_b;
  assign obs_a = {kif_a.key_level, kif_a.key_press, kif_a.key_release, kif_a.key_repeat};
  assign obs_b = {kif_b.key_level, kif_b.key_press, kif_b.key_release, kif_b.key_repeat};

  // reference model: raw samples reach the debouncer two edges later; a level is
  // accepted once DB consecutive samples since the last change all disagree with it;
  // repeats fall at press+LONG+k*REP while the key stays accepted as pressed.
  logic [4*N-1:0] exp_q[$];
  bit             rq[N][$];
  bit             hist[N][$];
  logic [N-1:0]   m_lvl;
  int             press_t[N];

  always @(posedge clk) begin
    logic [N-1:0] e_pr, e_rl, e_rp;
    bit p, flip, junk;
    int d;
    cyc++;
    e_pr = '0;
    e_rl = '0;
    e_rp = '0;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        rq[c].delete();
        rq[c].push_back(1'b0);
        rq[c].push_back(1'b0);
        hist[c].delete();
        m_lvl[c]   = 1'b0;
        press_t[c] = -1;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        p = rq[c].pop_front();
        rq[c].push_back(kif_a.key_raw[c]);
        hist[c].push_back(p);
        if (hist[c].size() > DB) junk = hist[c].pop_front();
        flip = (hist[c].size() == DB);
        for (int i = 0; i < hist[c].size(); i++)
          if (hist[c][i] == m_lvl[c]) flip = 1'b0;
        if (flip) begin
          m_lvl[c] = p;
          hist[c].delete();
          if (p) begin
            e_pr[c]    = 1'b1;
            press_t[c] = cyc;
          end else begin
            e_rl[c]    = 1'b1;
            press_t[c] = -1;
          end
        end else if (press_t[c] >= 0) begin
          d = cyc - press_t[c];
          e_rp[c] = (d >= LONG) && ((d - LONG) % REP == 0);
        end
      end
    end
    exp_q.push_back({m_lvl, e_pr, e_rl, e_rp});
  end

  // scoreboard
  always @(negedge clk) begin
    logic [4*N-1:0] exp_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_a !== exp_v) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got %h expected %h", cyc, obs_a, exp_v);
      end
    end
  end

  // driver tasks
  task automatic drive_raw(input int idx, input logic val);
    @(negedge clk);
    #1;
    kif_a.key_raw[idx] = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kif_a.key_raw = '1;
    repeat (4) @(negedge clk);
    checks++;
    if ({obs_a, kif_a.dbg_state, obs_b, kif_b.dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_hold got a=%h b=%h required 0", obs_a, obs_b);
    end
    kif_a.key_raw = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({obs_a, obs_b} !== '0) begin
      errors++;
      $display("FAIL reset_release got a=%h b=%h required 0", obs_a, obs_b);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_v;
    drive_raw(0, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      exp_v = {(k >= 5), (k == 5) ? 3'b001 : 3'b000};
      checks++;
      if ({kif_a.key_level[0], kif_a.key_press} !== exp_v) begin
        errors++;
        $display("FAIL clean_press k=%0d got %b required %b", k,
                 {kif_a.key_level[0], kif_a.key_press}, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    int pr_cnt = 0;
    int rl_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      drive_raw(1, (b % 2 == 0) ? 1'b1 : 1'b0);
      repeat (2) @(negedge clk);
    end
    drive_raw(1, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      pr_cnt += int'(kif_a.key_press[1]);
      rl_cnt += int'(kif_a.key_release[1]);
      checks++;
      if (kif_a.key_press[1] !== (k == 5)) begin
        errors++;
        $display("FAIL bounce_press k=%0d got %b required %b", k, kif_a.key_press[1], (k == 5));
      end
    end
    checks++;
    if (pr_cnt != 1 || rl_cnt != 0) begin
      errors++;
      $display("FAIL bounce_count got press=%0d release=%0d required 1/0", pr_cnt, rl_cnt);
    end
    drive_raw(1, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_long_press();
    int rl_cnt = 0;
    drive_raw(2, 1'b1);
    repeat (6) @(negedge clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++;
      if (kif_a.key_repeat[2] !== (j >= LONG && (j - LONG) % REP == 0)) begin
        errors++;
        $display("FAIL long_repeat +%0d got %b", j, kif_a.key_repeat[2]);
      end
    end
    drive_raw(2, 1'b0);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      rl_cnt += int'(kif_a.key_release[2]);
      if (k >= 5) begin
        checks++;
        if (kif_a.key_repeat[2] !== 1'b0) begin
          errors++;
          $display("FAIL long_no_repeat k=%0d got 1 required 0", k);
        end
      end
    end
    checks++;
    if (rl_cnt != 1) begin
      errors++;
      $display("FAIL long_release_count got %0d required 1", rl_cnt);
    end
  endtask

  task automatic test_collision();
    drive_raw(1, 1'b1);
    repeat (6) @(negedge clk);
    repeat (18) @(negedge clk);
    drive_raw(1, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (kif_a.key_repeat[1] !== 1'b1) begin
          errors++;
          $display("FAIL collision_first_repeat got %b required 1", kif_a.key_repeat[1]);
        end
      end
      if (k == 4) begin
        checks++;
        if (kif_a.dbg_state[3:2] !== REPEAT) begin
          errors++;
          $display("FAIL collision_state_before got %0d required %0d", kif_a.dbg_state[3:2], REPEAT);
        end
      end
    end
    checks++;
    if ({kif_a.key_release[1], kif_a.key_repeat[1], kif_a.dbg_state[3:2]} !== {1'b1, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL collision got rel=%b rep=%b st=%0d required rel=1 rep=0 st=0",
               kif_a.key_release[1], kif_a.key_repeat[1], kif_a.dbg_state[3:2]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    checks++;
    if (kif_a.dbg_state[1:0] !== REPEAT) begin
      errors++;
      $display("FAIL mid_hold_state got %0d required %0d", kif_a.dbg_state[1:0], REPEAT);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_a, kif_a.dbg_state} !== '0) begin
      errors++;
      $display("FAIL mid_hold_reset got %h required 0", obs_a);
    end
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (kif_a.key_press !== ((k == 5) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL mid_hold_repress k=%0d got %b", k, kif_a.key_press);
      end
    end
  endtask

  task automatic test_random();
    int pr_cnt[N];
    int rl_cnt[N];
    logic [N-1:0] start_lvl;
    int hold;
    start_lvl = kif_a.key_level;
    for (int c = 0; c < N; c++) begin
      pr_cnt[c] = 0;
      rl_cnt[c] = 0;
    end
    for (int it = 0; it < 70; it++) begin
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
      @(negedge clk);
      #1;
      kif_a.key_raw = N'($urandom_range(0, 7));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
          pr_cnt[c] += int'(kif_a.key_press[c]);
          rl_cnt[c] += int'(kif_a.key_release[c]);
        end
      end
    end
    #1;
    kif_a.key_raw = '0;
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        pr_cnt[c] += int'(kif_a.key_press[c]);
        rl_cnt[c] += int'(kif_a.key_release[c]);
      end
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (pr_cnt[c] + int'(start_lvl[c]) != rl_cnt[c] || kif_a.key_level[c] !== 1'b0) begin
        errors++;
        $display("FAIL random_balance ch%0d got press=%0d release=%0d level=%b", c,
                 pr_cnt[c], rl_cnt[c], kif_a.key_level[c]);
      end
    end
  endtask

  task automatic test_polarity();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== '0) begin
        errors++;
        $display("FAIL polarity_idle got %h required 0", obs_b);
      end
    end
    @(negedge clk);
    #1;
    kif_b.key_raw[0] = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({kif_b.key_level[0], kif_b.key_press[0]} !== {(k >= 5), (k == 5)}) begin
        errors++;
        $display("FAIL polarity_press k=%0d got %b", k, {kif_b.key_level[0], kif_b.key_press[0]});
      end
    end
    @(negedge clk);
    #1;
    kif_b.key_raw[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({kif_b.key_level[0], kif_b.key_release[0]} !== {(k < 5), (k == 5)}) begin
        errors++;
        $display("FAIL polarity_release k=%0d got %b", k, {kif_b.key_level[0], kif_b.key_release[0]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    kif_a.key_raw = '0;
    kif_b.key_raw = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_collision();
    test_reset_mid_hold();
    test_random();
    test_polarity();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
